// File: rtl/inst_fetch_unit.sv
// Purpose    : sequential instruction prefetcher feeding the decoder; stops after a halt word.
// Latency    : first word valid 2 cycles after FETCH entry; then 1 word/cycle under inst_ready=1.
// Backpressure: holds head while inst_ready=0; stops issuing reads once FIFO+in-flight read fill it.
// Ports: clk/rst_n (async active-low); start/start_addr begin fetch from IDLE/HALTED;
//        imem_rd_en/imem_addr/imem_rd_data synchronous memory (1-cycle read);
//        inst_valid/inst_data/inst_pc/inst_ready decoder handshake;
//        redirect_valid/redirect_addr flush+restart; busy (FETCH/DRAIN); done (halt accepted).
module inst_fetch_unit #(
    parameter int         INST_WIDTH = 32,
    parameter int         ADDR_WIDTH = 8,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] HALT_OP    = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  imem_rd_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rd_data,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  busy,
    output logic                  done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [INST_WIDTH-1:0] dat_q [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] dat_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pcs_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pcs_d [FIFO_DEPTH];

    logic active, redirect_eff, push, halt_push, pop, head_halt, halt_acc, room, rd_en;

    assign active       = (state_q == FETCH) || (state_q == DRAIN);
    assign redirect_eff = redirect_valid && active;
    // A response arriving in a redirect cycle belongs to the old stream.
    assign push         = pend_q && !redirect_eff;
    assign halt_push    = push && (imem_rd_data[INST_WIDTH-1:INST_WIDTH-4] == HALT_OP);
    assign inst_valid   = (count_q != '0);
    assign pop          = inst_valid && inst_ready;
    assign head_halt    = (dat_q[rd_ptr_q][INST_WIDTH-1:INST_WIDTH-4] == HALT_OP);
    assign halt_acc     = pop && head_halt && (state_q == DRAIN) && !redirect_eff;
    // The in-flight read already owns a slot, so count it against capacity.
    assign room         = (count_q + CW'(pend_q)) < CW'(FIFO_DEPTH);
    // Suppressing the read in the halt-push cycle leaves PC at halt address + 1.
    assign rd_en        = (state_q == FETCH) && !redirect_eff && !halt_push && room;

    assign imem_rd_en = rd_en;
    assign imem_addr  = rd_en ? pc_q : '0;
    assign inst_data  = inst_valid ? dat_q[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? pcs_q[rd_ptr_q] : '0;
    assign busy       = active;
    assign done       = halt_acc;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = rd_en;
        pend_addr_d = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dat_d       = dat_q;
        pcs_d       = pcs_q;

        if (push) begin
            dat_d[wr_ptr_q] = imem_rd_data;
            pcs_d[wr_ptr_q] = pend_addr_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d  = FETCH;
                    pc_d     = start_addr;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end
            end
            FETCH, DRAIN: begin
                if (redirect_eff) begin
                    state_d  = FETCH;
                    pc_d     = redirect_addr;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else if (state_q == FETCH) begin
                    if (halt_push) begin
                        state_d = DRAIN;
                        pc_d    = pend_addr_q + ADDR_WIDTH'(1);
                    end else if (rd_en) begin
                        pc_d = pc_q + ADDR_WIDTH'(1);
                    end
                end else if (halt_acc) begin
                    state_d = HALTED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dat_q[i] <= '0;
                pcs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dat_q       <= dat_d;
            pcs_q       <= pcs_d;
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Purpose    : directed bench for inst_fetch_unit with a memory model and in-order scoreboard.
// Latency    : memory model returns data one cycle after each read strobe.
// Backpressure: inst_ready driven per step; scoreboard pops on every accepted word.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_addr;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rd_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [7:0]  inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        mon_exp_done;
    logic        mon_en = 1'b0;
    logic [31:0] imem [256];
    int          vectors = 0;
    int          errors  = 0;

    inst_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_addr     (start_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rd_data   (imem_rd_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rd_data <= imem[imem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon_exp_done = 1'b0;
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_pc", 64'(inst_pc), 64'(mon_e.pc));
                    check("sb_data", 64'(inst_data), 64'(mon_e.dat));
                    mon_exp_done = (mon_e.dat[31:28] == 4'hF) && !redirect_valid;
                end
            end
            check("sb_done", 64'(done), 64'(mon_exp_done));
        end
    end

    task automatic push_range(input logic [7:0] a, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc  = a + 8'(i);
            e.dat = imem[e.pc];
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [7:0] a);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = a;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 200);
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        @(negedge clk);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_valid_after"}, 64'(inst_valid), 64'd0);
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) imem[i] = 32'(i);
        imem[8'h0A] = 32'hF000_0000;
        imem[8'h23] = 32'hF000_0000;
        imem[8'h43] = 32'hF000_0000;
        imem_rd_data   = '0;
        rst_n          = 1'b0;
        start          = 1'b0;
        start_addr     = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;

        // Reset state
        #3;
        check("rst_rd_en", 64'(imem_rd_en), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_data", 64'(inst_data), 64'd0);
        check("rst_pc", 64'(inst_pc), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Sequential stream at one word per cycle
        inst_ready = 1'b1;
        push_range(8'h00, 11);
        do_start(8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_valid && n < 50);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            check("seq_valid", 64'(inst_valid), 64'd1);
            check("seq_pc", 64'(inst_pc), 64'(i));
        end
        check("seq_done", 64'(done), 64'd1);
        @(negedge clk);
        check("seq_busy_after", 64'(busy), 64'd0);
        check("seq_sb_empty", 64'(exp_q.size()), 64'd0);

        // Restart from HALTED
        push_range(8'h20, 4);
        do_start(8'h20);
        check("restart_busy", 64'(busy), 64'd1);
        wait_done("restart");

        // Backpressure: head must hold while the FIFO fills
        inst_ready = 1'b0;
        push_range(8'h00, 11);
        do_start(8'h00);
        repeat (12) begin
            @(negedge clk);
            if (inst_valid) begin
                check("bp_hold_data", 64'(inst_data), 64'd0);
                check("bp_hold_pc", 64'(inst_pc), 64'd0);
            end
        end
        check("bp_rd_en_stalled", 64'(imem_rd_en), 64'd0);
        check("bp_valid", 64'(inst_valid), 64'd1);
        @(posedge clk); #1;
        inst_ready = 1'b1;
        wait_done("bp");

        // Redirect while pc=3 is being delivered
        push_range(8'h00, 11);
        do_start(8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(inst_valid && inst_pc == 8'd3) && n < 50);
        check("redir_at_pc3", 64'(inst_pc), 64'd3);
        redirect_valid = 1'b1;
        redirect_addr  = 8'h40;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        exp_q.delete();
        push_range(8'h40, 4);
        @(negedge clk);
        check("redir_valid_low", 64'(inst_valid), 64'd0);
        check("redir_first_rd", 64'(imem_rd_en), 64'd1);
        check("redir_first_addr", 64'(imem_addr), 64'h40);
        wait_done("redir");

        // PC wrap-around
        imem[8'h01] = 32'hF000_0000;
        push_range(8'hFE, 4);
        do_start(8'hFE);
        wait_done("wrap");
        imem[8'h01] = 32'h1;

        // Asynchronous reset with 3 words buffered
        inst_ready = 1'b0;
        do_start(8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_valid && n < 50);
        repeat (2) @(negedge clk);
        check("ar_valid_before", 64'(inst_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(inst_valid), 64'd0);
        check("ar_rd_en", 64'(imem_rd_en), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_pc", 64'(inst_pc), 64'd0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("ar_idle_valid", 64'(inst_valid), 64'd0);
            check("ar_idle_rd_en", 64'(imem_rd_en), 64'd0);
            check("ar_idle_busy", 64'(busy), 64'd0);
        end

        // Clean run after reset
        push_range(8'h00, 11);
        do_start(8'h00);
        wait_done("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
